// File: rtl/vec_elem_packer.sv
// Packs LANES element messages from the element queue into one vector word.
// A flush emits a partially filled word together with its lane-valid mask.
// Optional per-lane even parity output: define VEC_ELEM_PACKER_PARITY_EN.
module vec_elem_packer #(
    parameter int ELEM_W = 8,
    parameter int LANES  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ELEM_W-1:0]           recv_msg,
    input  logic                        recv_val,
    output logic                        recv_rdy,
    input  logic                        flush,
    output logic [ELEM_W*LANES-1:0]     send_msg,
    output logic [LANES-1:0]            send_mask,
    output logic                        send_val,
    input  logic                        send_rdy,
    output logic [$clog2(LANES+1)-1:0]  fill_cnt
`ifdef VEC_ELEM_PACKER_PARITY_EN
    ,
    output logic [LANES-1:0]            send_par
`endif
);
    localparam int CW = $clog2(LANES + 1);
    localparam int IW = $clog2(LANES);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t                    state_q;
    logic [ELEM_W*LANES-1:0]   msg_q;
    logic [LANES-1:0]          mask_q;
    logic [CW-1:0]             cnt_q;
    logic [CW-1:0]             cnt_d;
    logic [IW-1:0]             idx;
    logic                      accept;
    logic                      lastLane;
    logic                      goHold;
`ifdef VEC_ELEM_PACKER_PARITY_EN
    logic [LANES-1:0]          par_q;
`endif

    // While filling, the element count doubles as the next free lane index.
    assign idx      = cnt_q[IW-1:0];
    assign cnt_d    = cnt_q + CW'(1);
    assign accept   = recv_val && (state_q == FILL);
    assign lastLane = (idx == IW'(LANES - 1));
    assign goHold   = accept ? (lastLane || flush) : (flush && (cnt_q != '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            msg_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
`ifdef VEC_ELEM_PACKER_PARITY_EN
            par_q   <= '0;
`endif
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        for (int i = 0; i < LANES; i++) begin
                            if (idx == IW'(i)) begin
                                msg_q[i*ELEM_W +: ELEM_W] <= recv_msg;
                                mask_q[i]                 <= 1'b1;
`ifdef VEC_ELEM_PACKER_PARITY_EN
                                par_q[i]                  <= ^recv_msg;
`endif
                            end
                        end
                        cnt_q <= cnt_d;
                    end
                    if (goHold) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // Clearing on handshake keeps unfilled lanes zero in the next word.
                    if (send_rdy) begin
                        state_q <= FILL;
                        msg_q   <= '0;
                        mask_q  <= '0;
                        cnt_q   <= '0;
`ifdef VEC_ELEM_PACKER_PARITY_EN
                        par_q   <= '0;
`endif
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign recv_rdy  = (state_q == FILL);
    assign send_val  = (state_q == HOLD);
    assign send_msg  = msg_q;
    assign send_mask = mask_q;
    assign fill_cnt  = cnt_q;
`ifdef VEC_ELEM_PACKER_PARITY_EN
    assign send_par  = par_q;
`endif

endmodule

// File: tb/tb_vec_elem_packer.sv
// Self-checking bench for vec_elem_packer: directed vector table, corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_vec_elem_packer;
    localparam int ELEM_W = 8;
    localparam int LANES  = 4;
    localparam int CW     = $clog2(LANES + 1);

    logic                      clk = 1'b0;
    logic                      reset;
    logic [ELEM_W-1:0]         recvMsg;
    logic                      recvVal;
    logic                      recvRdy;
    logic                      flush;
    logic [ELEM_W*LANES-1:0]   sendMsg;
    logic [LANES-1:0]          sendMask;
    logic                      sendVal;
    logic                      sendRdy;
    logic [CW-1:0]             fillCnt;
`ifdef VEC_ELEM_PACKER_PARITY_EN
    logic [LANES-1:0]          sendPar;
`endif

    int checks = 0;
    int errors = 0;

    vec_elem_packer #(.ELEM_W(ELEM_W), .LANES(LANES)) dut (
        .clk       (clk),
        .reset     (reset),
        .recv_msg  (recvMsg),
        .recv_val  (recvVal),
        .recv_rdy  (recvRdy),
        .flush     (flush),
        .send_msg  (sendMsg),
        .send_mask (sendMask),
        .send_val  (sendVal),
        .send_rdy  (sendRdy),
        .fill_cnt  (fillCnt)
`ifdef VEC_ELEM_PACKER_PARITY_EN
        ,
        .send_par  (sendPar)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                    val;
        logic [ELEM_W-1:0]       msg;
        logic                    fl;
        logic                    sRdy;
        logic                    expRdy;
        logic                    expSv;
        logic [ELEM_W*LANES-1:0] expMsg;
        logic [LANES-1:0]        expMask;
        logic [CW-1:0]           expCnt;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string name, input logic eRdy, input logic eSv,
                            input logic [ELEM_W*LANES-1:0] eMsg,
                            input logic [LANES-1:0] eMask, input logic [CW-1:0] eCnt);
        checkOutput({name, ".recv_rdy"},  64'(recvRdy),  64'(eRdy));
        checkOutput({name, ".send_val"},  64'(sendVal),  64'(eSv));
        checkOutput({name, ".send_msg"},  64'(sendMsg),  64'(eMsg));
        checkOutput({name, ".send_mask"}, 64'(sendMask), 64'(eMask));
        checkOutput({name, ".fill_cnt"},  64'(fillCnt),  64'(eCnt));
    endtask

    // Drive inputs, then let one active edge pass and settle.
    task automatic applyStimulus(input logic val, input logic [ELEM_W-1:0] msg,
                                 input logic fl, input logic sRdy);
        recvVal = val;
        recvMsg = msg;
        flush   = fl;
        sendRdy = sRdy;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    // Reference model: the held elements as a queue plus a "word is waiting" flag.
    logic [ELEM_W-1:0] held[$];
    bit                holding;

    function automatic logic [ELEM_W*LANES-1:0] modelMsg();
        logic [ELEM_W*LANES-1:0] w = '0;
        foreach (held[i]) w[i*ELEM_W +: ELEM_W] = held[i];
        return w;
    endfunction

    function automatic logic [LANES-1:0] modelMask();
        logic [LANES-1:0] m = '0;
        foreach (held[i]) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [LANES-1:0] modelPar();
        logic [LANES-1:0] p = '0;
        foreach (held[i]) p[i] = ^held[i];
        return p;
    endfunction

    initial begin
        recvVal = 0; recvMsg = '0; flush = 0; sendRdy = 0;
        doReset();
        checkAll("reset", 1'b1, 1'b0, '0, '0, '0);

        // Directed vectors: expected values are the state after the edge.
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000011, 4'b0001, 3'd1};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00002211, 4'b0011, 3'd2};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00332211, 4'b0111, 3'd3};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44332211, 4'b1111, 3'd4};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'b0000, 3'd0};
        vecs[5]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000A1, 4'b0001, 3'd1};
        vecs[6]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000A2A1, 4'b0011, 3'd2};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000A2A1, 4'b0011, 3'd2};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000A2A1, 4'b0011, 3'd2};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'b0000, 3'd0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'b0000, 3'd0};
        vecs[11] = '{1'b1, 8'h5C, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000005C, 4'b0001, 3'd1};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'b0000, 3'd0};
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].val, vecs[i].msg, vecs[i].fl, vecs[i].sRdy);
            checkAll($sformatf("vec%0d", i), vecs[i].expRdy, vecs[i].expSv,
                     vecs[i].expMsg, vecs[i].expMask, vecs[i].expCnt);
        end

        // Held word under backpressure while upstream keeps offering and flush pulses.
        applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hB3, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hB4, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 8'hC1, (k % 2) == 0, 1'b0);
            checkAll($sformatf("hold%0d", k), 1'b0, 1'b1, 32'hB4B3B2B1, 4'b1111, 3'd4);
        end
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b1);
        checkAll("holdRelease", 1'b1, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0);
        checkAll("resumeLane0", 1'b1, 1'b0, 32'h000000C1, 4'b0001, 3'd1);
        applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC4, 1'b0, 1'b0);
        checkAll("resumeFull", 1'b0, 1'b1, 32'hC4C3C2C1, 4'b1111, 3'd4);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset with a partial word discards it immediately.
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h03, 1'b0, 1'b1);
        checkAll("preReset", 1'b1, 1'b0, 32'h00030201, 4'b0111, 3'd3);
        recvVal = 1'b0;
        reset = 1'b1;
        #1;
        checkAll("asyncReset", 1'b1, 1'b0, '0, '0, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 8'hD1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hD2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hD3, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hD4, 1'b0, 1'b0);
        checkAll("postReset", 1'b0, 1'b1, 32'hD4D3D2D1, 4'b1111, 3'd4);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

`ifdef VEC_ELEM_PACKER_PARITY_EN
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h07, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput("parFull", 64'(sendPar), 64'(4'b0101));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("parCleared", 64'(sendPar), 64'(4'b0000));
        applyStimulus(1'b1, 8'h01, 1'b1, 1'b0);
        checkOutput("parPartial", 64'(sendPar), 64'(4'b0001));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
`endif

        // Randomized traffic against the queue model.
        doReset();
        held.delete();
        holding = 0;
        begin
            logic [ELEM_W-1:0] pending;
            logic v, f, r, accepted;
            pending = ELEM_W'($urandom);
            for (int cyc = 0; cyc < 400; cyc++) begin
                v = ($urandom_range(0, 3) != 0);
                f = ($urandom_range(0, 4) == 0);
                r = ($urandom_range(0, 2) != 0);
                accepted = 1'b0;
                if (!holding) begin
                    if (v) begin
                        held.push_back(pending);
                        accepted = 1'b1;
                    end
                    if (held.size() == LANES || (f && held.size() > 0)) holding = 1;
                end else if (r) begin
                    held.delete();
                    holding = 0;
                end
                applyStimulus(v, pending, f, r);
                checkAll($sformatf("rand%0d", cyc), !holding, holding, modelMsg(),
                         modelMask(), CW'(held.size()));
`ifdef VEC_ELEM_PACKER_PARITY_EN
                checkOutput($sformatf("rand%0d.send_par", cyc), 64'(sendPar), 64'(modelPar()));
`endif
                if (accepted) pending = ELEM_W'($urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
